// File: rtl/nanov_pkg.sv
// nanov_pkg: shared types and constants for the nanoV sequencer.
//   state_t        - sequencer FSM states
//   NANOV_NOP      - addi x0,x0,0, presented to the core while not executing
//   CYCLE_IDLE     - cycle value presented outside EXEC
//   OPC_OP_IMM_OP  - instr[4:0] pattern shared by OP-IMM and OP (shift check)
//   OPC_STORE      - instr[6:2] pattern for stores
package nanov_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_EXEC      = 2'd2,
    ST_STORE_OUT = 2'd3
  } state_t;

  localparam logic [31:0] NANOV_NOP     = 32'h00000013;
  localparam logic [2:0]  CYCLE_IDLE    = 3'd7;
  localparam logic [4:0]  OPC_OP_IMM_OP = 5'b10011;
  localparam logic [4:0]  OPC_STORE     = 5'b01000;

endpackage

// File: rtl/nanov_instr_decode.sv
// nanov_instr_decode: combinational decode of the latched instruction.
// Ports:
//   instr      in  32 : latched instruction word
//   num_passes out 2  : 2 for shifts (slli/srli/srai/sll/srl/sra), else 1
//   is_store   out 1  : store opcode
//   j_imm      out 32 : sign-extended J-type immediate
import nanov_pkg::*;

module nanov_instr_decode (
  input  logic [31:0] instr,
  output logic [1:0]  num_passes,
  output logic        is_store,
  output logic [31:0] j_imm
);

  logic is_shift;
  // rd is never needed by the sequencer
  logic unused_rd;

  // funct3 = x01 selects the shift group in both OP-IMM and OP
  assign is_shift   = (instr[4:0] == OPC_OP_IMM_OP) && (instr[13:12] == 2'b01);
  assign num_passes = is_shift ? 2'd2 : 2'd1;
  assign is_store   = (instr[6:2] == OPC_STORE);
  assign j_imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
  assign unused_rd  = ^instr[11:7];

endmodule

// File: rtl/nanov_sequencer.sv
// nanov_sequencer: instruction sequencer and PC for the bit-serial nanoV core.
// Walks IDLE -> FETCH (32 serial bits, LSB first) -> EXEC (1 or 2 passes of
// 32 clocks) -> optional STORE_OUT -> FETCH/IDLE.
// Optional feature macro: NANOV_STORE_OUT_EN (serial store-data phase).
// Parameters: PC_WIDTH (<= 32), RESET_PC (multiple of 4).
// Ports:
//   clk, rstn               : clock, synchronous active-low reset
//   start                   : run enable, sampled at instruction boundaries
//   fetch_req, fetch_addr   : fetch in progress at fetch_addr
//   instr_bit(_valid)       : serial instruction stream
//   instr, cycle, counter   : drive the core
//   branch                  : taken jump from core, sampled at end of exec
//   shift_data_out          : core shifts store data this clock
//   data_bit_valid          : core data_out[0] is a valid store bit
//   data_ready              : memory accepts a store bit this clock
//   busy                    : not IDLE
import nanov_pkg::*;

module nanov_sequencer #(
  parameter int                  PC_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  output logic                fetch_req,
  output logic [PC_WIDTH-1:0] fetch_addr,
  input  logic                instr_bit,
  input  logic                instr_bit_valid,
  output logic [31:0]         instr,
  output logic [2:0]          cycle,
  output logic [4:0]          counter,
  input  logic                branch,
  output logic                shift_data_out,
  output logic                data_bit_valid,
  input  logic                data_ready,
  output logic                busy
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t              state;
  logic [31:0]         shreg;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [1:0]          num_passes;
  logic                is_store;
  logic [31:0]         j_imm;
  logic                last_pass;
  logic                go_store;
  logic                unused_imm;

  nanov_instr_decode u_decode (
    .instr      (instr),
    .num_passes (num_passes),
    .is_store   (is_store),
    .j_imm      (j_imm)
  );

  assign last_pass  = (cycle == {1'b0, num_passes - 2'd1});
  assign pc_next    = branch ? pc + j_imm[PC_WIDTH-1:0] : pc + PC_STEP;
  assign unused_imm = ^j_imm;

`ifdef NANOV_STORE_OUT_EN
  assign go_store       = is_store;
  // Memory handshake passes straight through: a bit moves only when accepted
  assign shift_data_out = (state == ST_STORE_OUT) && data_ready;
  assign data_bit_valid = (state == ST_STORE_OUT) && data_ready;
`else
  logic unused_store;
  assign go_store       = 1'b0;
  assign shift_data_out = 1'b0;
  assign data_bit_valid = 1'b0;
  assign unused_store   = data_ready ^ is_store;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      instr      <= NANOV_NOP;
      shreg      <= '0;
      cycle      <= CYCLE_IDLE;
      counter    <= '0;
      fetch_req  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_FETCH;
            fetch_req  <= 1'b1;
            busy       <= 1'b1;
            fetch_addr <= pc;
            counter    <= '0;
          end
        end

        ST_FETCH: begin
          if (instr_bit_valid) begin
            shreg   <= {instr_bit, shreg[31:1]};
            counter <= counter + 5'd1;
            if (counter == 5'd31) begin
              // the bit arriving with the transition is the MSB
              instr     <= {instr_bit, shreg[31:1]};
              state     <= ST_EXEC;
              fetch_req <= 1'b0;
              cycle     <= '0;
              counter   <= '0;
            end
          end
        end

        ST_EXEC: begin
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            if (!last_pass) begin
              cycle <= cycle + 3'd1;
            end else begin
              pc    <= pc_next;
              cycle <= CYCLE_IDLE;
              if (go_store) begin
                state <= ST_STORE_OUT;
              end else if (start) begin
                state      <= ST_FETCH;
                fetch_req  <= 1'b1;
                fetch_addr <= pc_next;
                instr      <= NANOV_NOP;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                instr <= NANOV_NOP;
              end
            end
          end
        end

        ST_STORE_OUT: begin
          if (data_ready) begin
            counter <= counter + 5'd1;
            if (counter == 5'd31) begin
              instr <= NANOV_NOP;
              if (start) begin
                state      <= ST_FETCH;
                fetch_req  <= 1'b1;
                fetch_addr <= pc;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_sequencer.sv
// tb_nanov_sequencer: directed self-checking bench for nanov_sequencer.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_nanov_sequencer;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SLLI = 32'h00209093;
  localparam logic [31:0] JAL1 = 32'h0100006F;
  localparam logic [31:0] JAL2 = 32'hFF9FF06F;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstn, start, instr_bit, instr_bit_valid, branch, data_ready;
  logic        fetch_req, shift_data_out, data_bit_valid, busy;
  logic [23:0] fetch_addr;
  logic [31:0] instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nanov_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr_bit(instr_bit), .instr_bit_valid(instr_bit_valid),
    .instr(instr), .cycle(cycle), .counter(counter), .branch(branch),
    .shift_data_out(shift_data_out), .data_bit_valid(data_bit_valid),
    .data_ready(data_ready), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // serial feed of bits [lo..hi] of w, one valid bit per clock
  task automatic feed(input logic [31:0] w, input int lo, input int hi);
    logic [31:0] v;
    v = w;
    for (int i = lo; i <= hi; i++) begin
      instr_bit_valid = 1'b1;
      instr_bit       = v[i];
      tick();
    end
    instr_bit_valid = 1'b0;
    instr_bit       = 1'b0;
  endtask

  // run n exec clocks, presenting br on the final one
  task automatic exec_steps(input int n, input logic br);
    for (int i = 0; i < n; i++) begin
      branch = (i == n - 1) ? br : 1'b0;
      tick();
    end
    branch = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; instr_bit = 1'b0; instr_bit_valid = 1'b0;
    branch = 1'b0; data_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({fetch_req, busy, cycle, counter, shift_data_out, data_bit_valid} !== {1'b0, 1'b0, 3'd7, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b busy=%b cyc=%0d cnt=%0d sdo=%b dbv=%b exp 0 0 7 0 0 0",
               fetch_req, busy, cycle, counter, shift_data_out, data_bit_valid);
    end
    checks++;
    if ({instr, fetch_addr} !== {NOP, 24'h0}) begin
      errors++;
      $display("FAIL reset_instr_pc got instr=%h addr=%h exp %h 000000", instr, fetch_addr, NOP);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_basic();
    start = 1'b1;
    tick();
    checks++;
    if ({fetch_req, busy, fetch_addr, counter} !== {1'b1, 1'b1, 24'h0, 5'd0}) begin
      errors++;
      $display("FAIL fetch_entry got req=%b busy=%b addr=%h cnt=%0d exp 1 1 000000 0",
               fetch_req, busy, fetch_addr, counter);
    end
    feed(ADDI, 0, 31);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({instr, cycle, counter, fetch_req} !== {ADDI, 3'd0, 5'(i), 1'b0}) begin
        errors++;
        $display("FAIL addi_exec[%0d] got instr=%h cyc=%0d cnt=%0d req=%b exp %h 0 %0d 0",
                 i, instr, cycle, counter, fetch_req, ADDI, i);
      end
      tick();
    end
    checks++;
    if ({fetch_req, fetch_addr, instr, cycle} !== {1'b1, 24'h4, NOP, 3'd7}) begin
      errors++;
      $display("FAIL addi_next_fetch got req=%b addr=%h instr=%h cyc=%0d exp 1 000004 %h 7",
               fetch_req, fetch_addr, instr, cycle, NOP);
    end
  endtask

  task automatic test_fetch_stall();
    feed(ADDI, 0, 7);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({counter, fetch_req, instr} !== {5'd8, 1'b1, NOP}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got cnt=%0d req=%b instr=%h exp 8 1 %h",
                 i, counter, fetch_req, instr, NOP);
      end
    end
    feed(ADDI, 8, 31);
    // 8 + 10 + 24 = 42 clocks after FETCH entry
    checks++;
    if ({instr, cycle, counter, fetch_req} !== {ADDI, 3'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL stall_exec_entry got instr=%h cyc=%0d cnt=%0d req=%b exp %h 0 0 0",
               instr, cycle, counter, fetch_req, ADDI);
    end
    exec_steps(32, 1'b0);
    checks++;
    if (fetch_addr !== 24'h8) begin
      errors++;
      $display("FAIL stall_next_addr got %h exp 000008", fetch_addr);
    end
  endtask

  task automatic test_jal_fwd();
    feed(JAL1, 0, 31);
    exec_steps(32, 1'b1);
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, 24'd24}) begin
      errors++;
      $display("FAIL jal_fwd got req=%b addr=%h exp 1 000018", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_shift();
    feed(SLLI, 0, 31);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({instr, cycle, counter} !== {SLLI, 3'(i / 32), 5'(i % 32)}) begin
        errors++;
        $display("FAIL shift_exec[%0d] got instr=%h cyc=%0d cnt=%0d exp %h %0d %0d",
                 i, instr, cycle, counter, SLLI, i / 32, i % 32);
      end
      tick();
    end
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, 24'd28}) begin
      errors++;
      $display("FAIL shift_next got req=%b addr=%h exp 1 00001c", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    feed(ADDI, 0, 19);
    checks++;
    if (counter !== 5'd20) begin
      errors++;
      $display("FAIL mid_fetch_cnt got %0d exp 20", counter);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({busy, fetch_req, counter, cycle, fetch_addr} !== {1'b0, 1'b0, 5'd0, 3'd7, 24'h0}) begin
      errors++;
      $display("FAIL mid_fetch_reset got busy=%b req=%b cnt=%0d cyc=%0d addr=%h exp 0 0 0 7 000000",
               busy, fetch_req, counter, cycle, fetch_addr);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if ({fetch_req, fetch_addr, counter} !== {1'b1, 24'h0, 5'd0}) begin
      errors++;
      $display("FAIL restart_fetch got req=%b addr=%h cnt=%0d exp 1 000000 0",
               fetch_req, fetch_addr, counter);
    end
  endtask

  task automatic test_jal_neg();
    feed(JAL2, 0, 31);
    exec_steps(32, 1'b1);
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, 24'hFFFFF8}) begin
      errors++;
      $display("FAIL jal_neg got req=%b addr=%h exp 1 fffff8", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_store();
    int acc;
    feed(SW, 0, 31);
    exec_steps(32, 1'b0);
`ifdef NANOV_STORE_OUT_EN
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({fetch_req, busy, cycle, instr, counter} !== {1'b0, 1'b1, 3'd7, SW, 5'(acc)}) begin
        errors++;
        $display("FAIL store_state[%0d] got req=%b busy=%b cyc=%0d instr=%h cnt=%0d exp 0 1 7 %h %0d",
                 i, fetch_req, busy, cycle, instr, counter, SW, acc);
      end
      data_ready = (i % 2 == 1);
      #1;
      checks++;
      if ({shift_data_out, data_bit_valid} !== {data_ready, data_ready}) begin
        errors++;
        $display("FAIL store_shift[%0d] got sdo=%b dbv=%b exp %b %b",
                 i, shift_data_out, data_bit_valid, data_ready, data_ready);
      end
      if (data_ready) acc++;
      tick();
    end
    data_ready = 1'b0;
    checks++;
    if ({fetch_req, fetch_addr, instr} !== {1'b1, 24'hFFFFFC, NOP}) begin
      errors++;
      $display("FAIL store_done got req=%b addr=%h instr=%h exp 1 fffffc %h",
               fetch_req, fetch_addr, instr, NOP);
    end
`else
    acc = 0;
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, 24'hFFFFFC}) begin
      errors++;
      $display("FAIL store_skip got req=%b addr=%h exp 1 fffffc", fetch_req, fetch_addr);
    end
    data_ready = 1'b1;
    #1;
    checks++;
    if ({shift_data_out, data_bit_valid} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL store_tied got sdo=%b dbv=%b exp 0 0 (acc=%0d)", shift_data_out, data_bit_valid, acc);
    end
    data_ready = 1'b0;
    tick();
`endif
  endtask

  task automatic test_start_drop();
    feed(ADDI, 0, 31);
    exec_steps(5, 1'b0);
    start = 1'b0;
    checks++;
    if ({busy, instr} !== {1'b1, ADDI}) begin
      errors++;
      $display("FAIL drop_mid got busy=%b instr=%h exp 1 %h", busy, instr, ADDI);
    end
    exec_steps(26, 1'b0);
    checks++;
    if ({busy, counter} !== {1'b1, 5'd31}) begin
      errors++;
      $display("FAIL drop_last got busy=%b cnt=%0d exp 1 31", busy, counter);
    end
    tick();
    checks++;
    if ({busy, fetch_req, instr, cycle, counter} !== {1'b0, 1'b0, NOP, 3'd7, 5'd0}) begin
      errors++;
      $display("FAIL drop_idle got busy=%b req=%b instr=%h cyc=%0d cnt=%0d exp 0 0 %h 7 0",
               busy, fetch_req, instr, cycle, counter, NOP);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_stays_idle got busy=%b exp 0", busy);
    end
    start = 1'b1;
    tick();
    // PC wrapped from fffffc to 0
    checks++;
    if ({fetch_req, fetch_addr} !== {1'b1, 24'h0}) begin
      errors++;
      $display("FAIL pc_wrap got req=%b addr=%h exp 1 000000", fetch_req, fetch_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fetch_stall();
    test_jal_fwd();
    test_shift();
    test_reset_mid_fetch();
    test_jal_neg();
    test_store();
    test_start_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanov_sequencer.md
# nanov_sequencer

Top-level controller for the bit-serial nanoV datapath. It sequences each instruction through serial fetch, one or two 32-clock execute passes and an optional serial store-data phase, and holds the PC. It drives the core's `instr`, `cycle`, `counter` and `shift_data_out` inputs and consumes its `branch` output. It sits between the core and the serial memory interface.

## Interface
- `PC_WIDTH`, default 24: program counter width in bits; byte address.
- `RESET_PC`, default 0: PC value loaded on reset; must be a multiple of 4.
- `clk` in 1: clock.
- `rstn` in 1: synchronous, active-low reset.
- `start` in 1: run enable, sampled at instruction boundaries.
- `fetch_req` out 1: a fetch is in progress at `fetch_addr`.
- `fetch_addr` out PC_WIDTH: current PC.
- `instr_bit` in 1: serial instruction bit, LSB first.
- `instr_bit_valid` in 1: `instr_bit` is valid this clock.
- `instr` out 32: instruction presented to the core.
- `cycle` out 3: execute pass index.
- `counter` out 5: bit index within the pass.
- `branch` in 1: taken-jump indication from the core.
- `shift_data_out` out 1: core shifts its stored data one bit this clock.
- `data_bit_valid` out 1: core `data_out[0]` is a valid store bit this clock.
- `data_ready` in 1: memory accepts a store bit this clock.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE: `fetch_req`=0, `instr`=NOP (32'h00000013), `cycle`=7, `counter`=0.
  - FETCH: `fetch_req`=1. Each clock with `instr_bit_valid`=1 does `shreg <= {instr_bit, shreg[31:1]}` and increments `counter`. If `instr_bit_valid`=0, `counter` holds. `instr` stays NOP and `cycle` stays 7.
  - EXEC: `instr` = latched word. `counter` increments every clock; `cycle` starts at 0.
  - STORE_OUT: `instr` = latched word and `cycle`=7. `shift_data_out` and `data_bit_valid` are both equal to `data_ready`. `counter` increments only when `data_ready`=1.
- Transitions:
  - IDLE→FETCH when `start`=1.
  - FETCH→EXEC on the valid bit at `counter`=31. `instr <= {instr_bit, shreg[31:1]}`; `counter` and `cycle` reset to 0.
  - EXEC pass count:
    - 2 passes for shifts: `instr[4:0]`=10011 and `instr[13:12]`=01.
    - 1 pass for all other instructions.
  - At `counter`=31 of the last pass, the next state is:
    - STORE_OUT if `instr[6:2]`=01000;
    - otherwise FETCH if `start`=1;
    - otherwise IDLE.
  - STORE_OUT at an accepted bit with `counter`=31 → FETCH if `start`=1, otherwise IDLE.
- PC update at the end of the last EXEC pass:
  - `branch`=1 at `counter`=31: PC += J-imm. J-imm = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Otherwise PC += 4.
  - The sum is truncated to PC_WIDTH and wraps modulo 2^PC_WIDTH.
- `start` deasserting mid-instruction never aborts. The block halts at the next boundary.

## Timing
- Reset values:
  - state IDLE, PC = RESET_PC, `instr` = NOP;
  - `cycle`=7, `counter`=0;
  - `fetch_req`, `shift_data_out`, `data_bit_valid` = 0;
  - `busy`=0.
- Reset asserted in any state returns every register to its reset value on the next edge.
- Start-up:
  - `start` sampled high in IDLE gives `fetch_req`=1 on the next clock.
  - The best-case fetch is 32 clocks.
- Execute length:
  - EXEC for a non-shift is 32 clocks; a shift takes 64 (`cycle` 0 then 1).
  - Minimum instruction time is 64 clocks, or 96 for shifts. STORE_OUT adds at least 32.
- `fetch_addr` changes only on the clock entering FETCH. It is stable for the whole fetch.
- If `instr_bit_valid` and a FETCH→EXEC transition coincide, that bit is the MSB.

## Configuration
- `NANOV_STORE_OUT_EN`:
  - Defined: STORE_OUT exists as above.
  - Undefined: stores end after EXEC like any other instruction. `shift_data_out`, `data_bit_valid` are tied 0 and `data_ready` is ignored.

## Structure
- Package `nanov_pkg`:
  - the state enum;
  - constants `NANOV_NOP` (32'h00000013) and `CYCLE_IDLE` (3'd7);
  - opcode field constants `OPC_OP_IMM_OP` (5'b10011 on instr[4:0]) and `OPC_STORE` (5'b01000 on instr[6:2]).
- One sub-module, `nanov_instr_decode`: combinational, producing `num_passes`, `is_store` and `j_imm`.
- FSM, counter, shift register and PC stay in the top module.

## Test plan
- Reset, then `start`=1 with 32 continuous valid bits of 32'h00500093 (addi x1,x0,5):
  - `fetch_addr`=0, `instr`=32'h00500093 for 32 EXEC clocks with `cycle`=0;
  - then the next fetch at `fetch_addr`=4.
- Fetch stall: `instr_bit_valid` low for 10 clocks after bit 7 → `counter` holds at 8 and EXEC begins 42 clocks after FETCH entry.
- Shift 32'h00209093 (slli x1,x1,2) → 64 EXEC clocks, with `cycle` 0 then 1 and `counter` 0..31 in each pass.
- JAL 32'h0100006F at PC 8 with `branch`=1 at `counter`=31 → next `fetch_addr`=24. JAL 32'hFF9FF06F at PC 0 → `fetch_addr` = 2^24−8.
- sw 32'h0020A023 with `data_ready` low on alternate clocks:
  - 64 STORE_OUT clocks;
  - `shift_data_out` equals `data_ready` on every one of them;
  - exactly 32 accepted bits.
- Reset while in FETCH at `counter`=20 → next clock IDLE, `counter`=0, PC = RESET_PC.
- `start` dropped mid-EXEC → instruction completes, then `busy`=0.
